// File: rtl/seven_seg_pkg.sv
// Shared definitions for both ends of the two-digit seven-segment scan bus:
// segment patterns, segment bit order, digit-select polarity and the
// receiver FSM state type.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NUM_DIGITS = 16;

  // Digit select: 1 = most significant digit on the bus.
  localparam logic CTRL_MSD = 1'b1;

  // Segment patterns indexed by hex digit, bit order {G,F,E,D,C,B,A}, bit 0 = A.
  localparam logic [SEG_W-1:0] SEG_TABLE [NUM_DIGITS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One bus observation: digit select plus segment lines.
  typedef struct packed {
    logic             ctrl;
    logic [SEG_W-1:0] seg;
  } scan_bus_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } scan_state_e;

  // Encoder used by the display-driving side.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIGIT_W-1:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/seven_seg_scan_receiver_seg_to_hex.sv
// seg_to_hex: combinational decode of a segment pattern back to a hex digit.
//   seg_i   : 7-bit pattern {G,F,E,D,C,B,A}
//   digit_o : recovered digit (0 when no match)
//   valid_o : pattern matched a table entry
module seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0]   seg_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               valid_o
);

  // Table search; patterns are unique so at most one entry matches.
  always_comb begin
    digit_o = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (seg_i == SEG_TABLE[i]) begin
        digit_o = DIGIT_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_receiver.sv
// seven_seg_scan_receiver: recovers the two hex digits from a multiplexed
// two-digit seven-segment bus driven on asynchronous pins.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   seg_i          : segment lines {G,F,E,D,C,B,A}
//   ctrl_i         : digit select (1 = most significant digit)
//   msd_o, lsd_o   : last recovered digit pair
//   pair_valid_o   : one-cycle strobe, msd_o/lsd_o just updated together
//   err_o          : one-cycle strobe, settled pattern matched no digit
module seven_seg_scan_receiver
  import seven_seg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SEG_W-1:0]    seg_i,
  input  logic                ctrl_i,
  output logic [DIGIT_W-1:0]  msd_o,
  output logic [DIGIT_W-1:0]  lsd_o,
  output logic                pair_valid_o,
  output logic                err_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);

  scan_bus_t sync_q [SYNC_STAGES];
  scan_bus_t bus_s;
  scan_bus_t bus_q;

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic               first_q, first_d;
  logic [DIGIT_W-1:0] msd_h_q, msd_h_d;
  logic [DIGIT_W-1:0] lsd_h_q, lsd_h_d;
  logic               got_msd_q, got_msd_d;
  logic               got_lsd_q, got_lsd_d;
  logic [DIGIT_W-1:0] msd_q, msd_d;
  logic [DIGIT_W-1:0] lsd_q, lsd_d;
  logic               pair_valid_q, pair_valid_d;
  logic               err_c;

  logic [DIGIT_W-1:0] dec_digit;
  logic               dec_valid;
  logic               ctrl_chg;
  logic               bus_chg;

  // Input synchroniser on every bus bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bus_q <= '0;
    end else begin
      sync_q[0] <= scan_bus_t'({ctrl_i, seg_i});
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bus_q <= bus_s;
    end
  end

  assign bus_s    = sync_q[SYNC_STAGES-1];
  assign ctrl_chg = (bus_s.ctrl != bus_q.ctrl);
  assign bus_chg  = (bus_s != bus_q);

  seg_to_hex u_seg_to_hex (
    .seg_i   (bus_s.seg),
    .digit_o (dec_digit),
    .valid_o (dec_valid)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_WAIT;
      stable_cnt_q <= '0;
      first_q      <= 1'b1;
      msd_h_q      <= '0;
      lsd_h_q      <= '0;
      got_msd_q    <= 1'b0;
      got_lsd_q    <= 1'b0;
      msd_q        <= '0;
      lsd_q        <= '0;
      pair_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      first_q      <= first_d;
      msd_h_q      <= msd_h_d;
      lsd_h_q      <= lsd_h_d;
      got_msd_q    <= got_msd_d;
      got_lsd_q    <= got_lsd_d;
      msd_q        <= msd_d;
      lsd_q        <= lsd_d;
      pair_valid_q <= pair_valid_d;
    end
  end

  // Phase tracking, sampling and pairing.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    first_d      = first_q;
    msd_h_d      = msd_h_q;
    lsd_h_d      = lsd_h_q;
    got_msd_d    = got_msd_q;
    got_lsd_d    = got_lsd_q;
    msd_d        = msd_q;
    lsd_d        = lsd_q;
    pair_valid_d = 1'b0;
    err_c        = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        // After reset the bus leaving its cleared value counts as a phase start.
        if (ctrl_chg || (first_q && bus_chg)) begin
          state_d      = ST_SETTLE;
          stable_cnt_d = '0;
          first_d      = 1'b0;
        end
      end
      ST_SETTLE: begin
        // Any change restarts the count; a ctrl change just starts a new phase.
        if (bus_chg) begin
          stable_cnt_d = '0;
        end else if (stable_cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else if (stable_cnt_q < CNT_MAX) begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        state_d = ST_WAIT;
        if (dec_valid) begin
          if (bus_s.ctrl == CTRL_MSD) begin
            msd_h_d   = dec_digit;
            got_msd_d = 1'b1;
          end else begin
            lsd_h_d   = dec_digit;
            got_lsd_d = 1'b1;
          end
        end else begin
          err_c = 1'b1;
          if (bus_s.ctrl == CTRL_MSD) got_msd_d = 1'b0;
          else                        got_lsd_d = 1'b0;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Completed pair is published on the edge that closes the sample.
    if (got_msd_d && got_lsd_d) begin
      msd_d        = msd_h_d;
      lsd_d        = lsd_h_d;
      pair_valid_d = 1'b1;
      got_msd_d    = 1'b0;
      got_lsd_d    = 1'b0;
    end
  end

  assign msd_o        = msd_q;
  assign lsd_o        = lsd_q;
  assign pair_valid_o = pair_valid_q;
  // Error strobe is decoded from registered state in the sample cycle itself.
  assign err_o        = err_c;

endmodule

// File: tb/tb_seven_seg_scan_receiver.sv
// Bench for seven_seg_scan_receiver (SYNC_STAGES=2, SETTLE_CYCLES=4):
// directed scenarios plus a randomised phase stream, checked against a
// phase-level reference model.
module tb_seven_seg_scan_receiver;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [6:0] seg_i;
  logic       ctrl_i;
  logic [3:0] msd_o;
  logic [3:0] lsd_o;
  logic       pair_valid_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  seven_seg_scan_receiver #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .seg_i        (seg_i),
    .ctrl_i       (ctrl_i),
    .msd_o        (msd_o),
    .lsd_o        (lsd_o),
    .pair_valid_o (pair_valid_o),
    .err_o        (err_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Segment encoding of the display-driving side, digit -> pattern.
  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Observed strobes.
  logic [7:0] got_q [$];
  int         err_seen  = 0;
  int         both_seen = 0;

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (pair_valid_o === 1'b1) got_q.push_back({msd_o, lsd_o});
      if (err_o === 1'b1) err_seen++;
      if (pair_valid_o === 1'b1 && err_o === 1'b1) both_seen++;
    end
  end

  // Phase-level reference model: a phase of >= 6 stable pin cycles is sampled
  // when armed; a ctrl change (or the first phase after reset) arms, a sample disarms.
  bit         armed;
  bit         last_c;
  bit         have [2];
  logic [3:0] hold [2];
  logic [7:0] exp_q [$];
  int         exp_err;
  logic [3:0] exp_msd;
  logic [3:0] exp_lsd;

  function automatic int dec7(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (tbl[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    armed   = 1'b1;
    last_c  = 1'b0;
    have[0] = 1'b0; have[1] = 1'b0;
    hold[0] = 4'h0; hold[1] = 4'h0;
    exp_msd = 4'h0; exp_lsd = 4'h0;
  endtask

  task automatic model_phase(input bit c, input logic [6:0] s, input int len);
    int d;
    if (c != last_c) armed = 1'b1;
    last_c = c;
    if (armed && len >= 6) begin
      armed = 1'b0;
      d = dec7(s);
      if (d >= 0) begin
        hold[c] = 4'(d);
        have[c] = 1'b1;
        if (have[0] && have[1]) begin
          exp_q.push_back({hold[1], hold[0]});
          exp_msd = hold[1];
          exp_lsd = hold[0];
          have[0] = 1'b0; have[1] = 1'b0;
        end
      end else begin
        exp_err++;
        have[c] = 1'b0;
      end
    end
  endtask

  // Hold a bus value for len clock edges; called and returns on a falling edge.
  task automatic run_phase(input bit c, input logic [6:0] s, input int len);
    ctrl_i = c;
    seg_i  = s;
    repeat (len) @(negedge clk_i);
    model_phase(c, s, len);
  endtask

  task automatic settle_wait();
    repeat (3) @(negedge clk_i);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pairs"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_errs"}, 32'(err_seen), 32'(exp_err));
    check({tag, "_msd"}, 32'(msd_o), 32'(exp_msd));
    check({tag, "_lsd"}, 32'(lsd_o), 32'(exp_lsd));
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  initial begin
    bit         c, prev_c;
    logic [6:0] s, prev_s;
    int         len;

    exp_err = 0;
    model_reset();
    rst_ni = 1'b0;
    ctrl_i = 1'b0;
    seg_i  = 7'h00;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_msd", 32'(msd_o), 32'h0);
    check("rst_lsd", 32'(lsd_o), 32'h0);
    check("rst_pv",  32'(pair_valid_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic pair with exact strobe timing on the second phase.
    run_phase(1'b1, 7'h4F, 10);
    ctrl_i = 1'b0;
    seg_i  = 7'h7F;
    repeat (7) @(negedge clk_i);
    #1;
    check("t1_pv_early", 32'(pair_valid_o), 32'h0);
    check("t1_err_in_sample", 32'(err_o), 32'h0);
    @(negedge clk_i);
    #1;
    check("t1_pv_at7", 32'(pair_valid_o), 32'h1);
    check("t1_msd_at7", 32'(msd_o), 32'h3);
    check("t1_lsd_at7", 32'(lsd_o), 32'h8);
    repeat (2) @(negedge clk_i);
    model_phase(1'b0, 7'h7F, 10);
    settle_wait();
    compare_all("t1");

    // Glitching segments within the lsd phase.
    run_phase(1'b1, 7'h7D, 10);
    for (int i = 0; i < 4; i++) run_phase(1'b0, (i % 2 == 0) ? 7'h06 : 7'h07, 2);
    run_phase(1'b0, 7'h6D, 10);
    settle_wait();
    compare_all("t2");

    // Invalid pattern after a good pair.
    run_phase(1'b1, 7'h4F, 10);
    run_phase(1'b0, 7'h7F, 10);
    run_phase(1'b1, 7'h66, 10);
    run_phase(1'b0, 7'h00, 10);
    settle_wait();
    compare_all("t3");

    // Short phase leaves the held msd (4) intact.
    run_phase(1'b1, 7'h06, 3);
    run_phase(1'b0, 7'h5B, 10);
    settle_wait();
    compare_all("t4");

    // Reset during an lsd settle.
    run_phase(1'b1, 7'h6D, 10);
    ctrl_i = 1'b0;
    seg_i  = 7'h07;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_msd", 32'(msd_o), 32'h0);
    check("t5_rst_lsd", 32'(lsd_o), 32'h0);
    check("t5_rst_pv",  32'(pair_valid_o), 32'h0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_phase(1'b0, 7'h07, 12);
    settle_wait();
    compare_all("t5_lsd_only");
    run_phase(1'b1, 7'h4F, 8);
    settle_wait();
    compare_all("t5_pair");

    // Full sweep of all digit pairs at minimum phase length.
    rst_ni = 1'b0;
    ctrl_i = 1'b0;
    seg_i  = 7'h00;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int m = 0; m < 16; m++) begin
      for (int l = 0; l < 16; l++) begin
        run_phase(1'b1, tbl[m], 6);
        run_phase(1'b0, tbl[l], 6);
      end
    end
    settle_wait();
    check("t6_pulses", 32'(got_q.size()), 32'd256);
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("t6_driven%0d", i), 32'(got_q[i]), 32'(i));
    compare_all("t6");

    // Randomised phase stream with glitches, short phases and bad patterns.
    prev_c = 1'b0;
    prev_s = tbl[15];
    for (int n = 0; n < 120; n++) begin
      do begin
        c = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) s = 7'($urandom);
        else                           s = tbl[$urandom_range(0, 15)];
      end while (c == prev_c && s == prev_s);
      case ($urandom_range(0, 8))
        0: len = 2;
        1: len = 3;
        2: len = 4;
        3: len = 6;
        4: len = 7;
        5: len = 8;
        6: len = 9;
        7: len = 10;
        default: len = 12;
      endcase
      run_phase(c, s, len);
      prev_c = c;
      prev_s = s;
    end
    c = ~prev_c;
    run_phase(c, tbl[$urandom_range(0, 15)], 10);
    settle_wait();
    compare_all("t7");

    check("strobe_exclusive", 32'(both_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
